// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
//
// Purpose: shared constants for the single-cycle MIPS data-side responder.
//          Holds the MMIO register offsets, the STATUS bit positions, the
//          default MMIO page base, and a small decoder that maps a
//          word-aligned MMIO offset onto a register select.
//
// Contents:
//   MMIO_BASE_DEFAULT      default MMIO page base (only [31:16] is decoded)
//   CYCLE_OFS..HALT_OFS    register offsets within the MMIO page
//   STATUS_*_BIT           bit positions inside the STATUS word
//   mmio_reg_e             register select produced by decode_ofs()
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [15:0] CYCLE_OFS  = 16'h0000;
  localparam logic [15:0] TXDATA_OFS = 16'h0004;
  localparam logic [15:0] STATUS_OFS = 16'h0008;
  localparam logic [15:0] HALT_OFS   = 16'h000C;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_BERR_BIT  = 3;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 4;

  typedef enum logic [2:0] {
    REG_CYCLE,
    REG_TXDATA,
    REG_STATUS,
    REG_HALT,
    REG_NONE
  } mmio_reg_e;

  // Maps a word-aligned page offset to a register; anything unmapped
  // becomes REG_NONE so the top level can flag bus errors on writes.
  function automatic mmio_reg_e decode_ofs(input logic [15:0] ofs);
    mmio_reg_e sel;
    case (ofs)
      CYCLE_OFS:  sel = REG_CYCLE;
      TXDATA_OFS: sel = REG_TXDATA;
      STATUS_OFS: sel = REG_STATUS;
      HALT_OFS:   sel = REG_HALT;
      default:    sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// ---------------------------------------------------------------------------
// mmio_tx_fifo
//
// Purpose: synchronous transmit FIFO for the MMIO page. Written by stores to
//          TXDATA, drained by an external valid/ready consumer.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (empties the FIFO)
//   push       enqueue push_data at this edge
//   push_data  word to enqueue
//   pop        dequeue the head at this edge (ignored while empty)
//   head       current head word, 0 while empty
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // A push into a full FIFO only lands when a pop frees a slot at the same
  // edge; a pop from an empty FIFO never happens.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_dmem_mmio.sv
// ---------------------------------------------------------------------------
// mips_dmem_mmio
//
// Purpose: data-side responder for the single-cycle MIPS core. Word RAM plus
//          an MMIO page with a cycle counter, a TX FIFO, STATUS and HALT.
//          Reads are combinational; every write commits at the rising edge.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   mem_addr     byte address from the core
//   mem_write    store data from the core
//   mem_we       store strobe
//   mem_read     load data, combinational from mem_addr
//   out_data     TX FIFO head word (0 when empty)
//   out_valid    TX FIFO non-empty
//   out_ready    consumer accepts the head this cycle
//   halted       sticky halt flag
//   cycle_count  current CYCLE value
//   bus_err      sticky bus-error flag (STATUS bit 3)
// ---------------------------------------------------------------------------
module mips_dmem_mmio
  import mips_mem_pkg::*;
#(
  parameter int          RAM_AW     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write,
  input  logic        mem_we,
  output logic [31:0] mem_read,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic        bus_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  logic              misaligned;
  logic [15:0]       ofs_aligned;
  mmio_reg_e         sel;

  logic              wr_ok;
  logic              ram_we;
  logic              push;
  logic              pop;
  logic              status_wr;
  logic              halt_wr;
  logic              bad_wr;
  logic              ovf_set;
  logic              overflow;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;
  logic [31:0]       status_word;

  // Address decode. Misaligned reads fall back to the aligned word, so the
  // MMIO offset and RAM index both ignore the low two address bits.
  assign is_mmio     = (mem_addr[31:16] == MMIO_BASE[31:16]);
  assign misaligned  = (mem_addr[1:0] != 2'b00);
  assign ofs_aligned = {mem_addr[15:2], 2'b00};
  assign sel         = decode_ofs(ofs_aligned);
  assign ram_idx     = mem_addr[RAM_AW+1:2];

  // Write qualification. A misaligned store never reaches any target; a
  // store to CYCLE is silently ignored, a store to an unmapped offset is
  // an error.
  assign wr_ok     = mem_we && !misaligned;
  assign ram_we    = wr_ok && !is_mmio;
  assign push      = wr_ok && is_mmio && (sel == REG_TXDATA);
  assign status_wr = wr_ok && is_mmio && (sel == REG_STATUS);
  assign halt_wr   = wr_ok && is_mmio && (sel == REG_HALT);
  assign bad_wr    = mem_we && (misaligned || (is_mmio && (sel == REG_NONE)));

  assign pop     = out_valid && out_ready;
  assign ovf_set = push && fifo_full && !pop;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (32)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_write),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_data  = fifo_head;
  assign out_valid = !fifo_empty;

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= mem_write;
  end

  // Free-running cycle counter, frozen once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Halt is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (halt_wr) begin
      halted <= 1'b1;
    end
  end

  // Sticky error flags with write-1-to-clear through STATUS. The set event
  // is tested first so it wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (status_wr && mem_write[STATUS_OVF_BIT]) begin
        overflow <= 1'b0;
      end
      if (bad_wr) begin
        bus_err <= 1'b1;
      end else if (status_wr && mem_write[STATUS_BERR_BIT]) begin
        bus_err <= 1'b0;
      end
    end
  end

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_OVF_BIT]   = overflow;
    status_word[STATUS_BERR_BIT]  = bus_err;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  // Combinational load path so a single-cycle lw completes in one cycle.
  always_comb begin
    mem_read = '0;
    if (is_mmio) begin
      case (sel)
        REG_CYCLE:  mem_read = cycle_count;
        REG_STATUS: mem_read = status_word;
        REG_HALT:   mem_read = {31'b0, halted};
        default:    mem_read = '0;
      endcase
    end else begin
      mem_read = ram[ram_idx];
    end
  end

endmodule

// File: doc/mips_dmem_mmio.md
Name: mips_dmem_mmio

Overview:
Data-side responder for the single-cycle MIPS core. It sits on the core's mem_addr/mem_write/mem_we/mem_read port.
- Word-addressed data RAM.
- Memory-mapped I/O page containing a cycle counter, a transmit FIFO drained by an external valid/ready consumer, a status register and a halt register.
- Reads are combinational, so a single-cycle lw completes in one cycle. All writes commit on the rising clock edge.

Parameters:
RAM_AW, 8, RAM word-address width (2^RAM_AW words, default 256).
FIFO_DEPTH, 4, TX FIFO entries (power of two, at least 2).
MMIO_BASE, 32'hFFFF0000, MMIO page base; decode compares bits [31:16].

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
mem_addr  in  32  byte address from core
mem_write  in  32  store data from core
mem_we  in  1  store strobe, sampled at posedge
mem_read  out  32  load data, combinational from mem_addr
out_data  out  32  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
halted  out  1  sticky halt flag
cycle_count  out  32  current CYCLE value
bus_err  out  1  sticky bus-error flag (mirrors STATUS[3])

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- While rst is sampled high, the following are cleared: cycle_count=0, FIFO emptied, out_valid=0, out_data=0, halted=0, overflow=0, bus_err=0.
- RAM contents are not affected by reset. The simulation model initialises RAM to zero.

Address decode:
- MMIO when mem_addr[31:16]==MMIO_BASE[31:16]. Otherwise RAM.
- RAM index is mem_addr[RAM_AW+1:2]. Higher address bits alias (wrap).
- Misaligned access (mem_addr[1:0]!=0): a write is dropped and sets bus_err. A read returns the aligned word.

MMIO registers (offset = mem_addr[15:0]):
- 0x0000 CYCLE, read-only.
  - Increments by 1 on each posedge where rst=0 and halted=0. Wraps at 2^32.
  - Writes are ignored.
- 0x0004 TXDATA, write-only.
  - A write pushes mem_write into the FIFO.
  - If the FIFO is full and no pop happens that cycle, the data is dropped and overflow is set.
  - Reads return 0.
- 0x0008 STATUS, read; write-1-to-clear on bits 2 and 3.
  - Bit 0 full, bit 1 empty, bit 2 overflow, bit 3 bus_err, bits [11:8] count. Other bits read 0.
  - If a clear and a new set event occur in the same cycle, set wins.
- 0x000C HALT.
  - Any write sets halted at the next edge. halted is sticky until reset.
  - Reads return {31'b0, halted}.
- Any other MMIO offset reads 0. A write there is ignored and sets bus_err.

FIFO:
- out_valid = !empty. out_data = head entry, or 0 when empty.
- A pop occurs at the posedge where out_valid && out_ready.
- Push and pop in the same cycle:
  - Full: both happen, count unchanged, no overflow.
  - Empty: the pop is not possible; the push lands and out_valid rises next cycle.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

Write latency: stored data is visible on mem_read one cycle after the write edge. Latency for RAM, STATUS and HALT is 1 cycle.

While halted: stores are still processed and the FIFO still drains. Only CYCLE is frozen.

Decomposition:
- Package mips_mem_pkg holds:
  - MMIO offset constants CYCLE_OFS, TXDATA_OFS, STATUS_OFS, HALT_OFS.
  - STATUS bit-position constants.
  - Default MMIO_BASE.
- Sub-module mmio_tx_fifo is a synchronous valid/ready FIFO.
  - Inputs: push, push_data, pop.
  - Outputs: head, full, empty, count.
  - It is instantiated once.
- RAM, decode and registers stay in the top level.

Test Plan:
1. RAM round trip: write 0x14 at 0x0 and 0x8 at 0x4. Reading 0x0 returns 0x00000014 and reading 0x4 returns 0x00000008. Reading 0x400 (alias of word 0) returns 0x00000014.
2. Counter: deassert rst, wait 10 posedges, read 0xFFFF0000 -> 0x0000000A. A write of 0x55 there -> value keeps incrementing and is unaffected by the write.
3. FIFO overflow and drain:
   - With out_ready=0, write 0xA, 0xB, 0xC, 0xD, 0xE to 0xFFFF0004. STATUS then reads 0x00000405 (count 4, overflow, full).
   - Set out_ready=1. out_data shows 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles, then out_valid=0 and STATUS reads 0x00000006.
   - Write 0x4 to STATUS -> overflow clears, STATUS reads 0x00000002.
4. Full push with pop: fill to 4 entries, then hold out_ready=1 while writing 0xF. Count stays 4, overflow stays 0, and 0xF is the last word drained.
5. Errors:
   - Write 0x1234 to 0x6 -> word 1 unchanged and bus_err=1.
   - Write 0x8 to STATUS -> bus_err=0.
   - Write to 0xFFFF0010 -> bus_err=1.
6. Halt and reset: write to 0xFFFF000C -> halted=1 next cycle and cycle_count frozen for 5 cycles. Pulse rst mid-drain with 2 entries queued -> halted=0, cycle_count=0, out_valid=0, and RAM data retained.
